// File: rtl/mem_port_arbiter.sv
// Shares the single data-cache request port between issued memory uops and the committed store-buffer drain.
// Define MEM_ARB_PERF_EN to add the perf_loads / perf_stores / perf_port_stall counters.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access in flight; grants the issue uop or the drain store
// S_REQ  | captured access presented on the cache port until accepted
// S_WAIT | load accepted by the cache, waiting for its response

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              iss_valid,
    input  logic              iss_is_store,
    input  logic              iss_unsigned,
    input  logic [1:0]        iss_size,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_wdata,
    input  logic [TAG_W-1:0]  iss_prf_index,
    output logic              ex_busy,

    input  logic              sb_valid,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [DATA_W-1:0] sb_wdata,
    input  logic [1:0]        sb_size,
    output logic              sb_ready,

    input  logic              flush,

    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_we,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [DATA_W-1:0] dc_req_wdata,
    output logic [1:0]        dc_req_size,
    input  logic              dc_resp_valid,
    input  logic [DATA_W-1:0] dc_resp_rdata,

    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_prf_index,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_port_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [TAG_W-1:0]  prf_q, prf_d;
    logic              kill_q, kill_d;
    logic              src_q, src_d;
    logic [7:0]        starve_q, starve_d;
    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_prf_q, wb_prf_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              starving;
    logic              grant_iss;
    logic              grant_sb;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_data;

    assign starving  = (starve_q == 8'(STARVE_LIMIT));
    assign ex_busy   = (state_q != S_IDLE) | (starving & sb_valid);
    assign grant_iss = (state_q == S_IDLE) & iss_valid & ~ex_busy & ~flush;
    assign grant_sb  = (state_q == S_IDLE) & ~grant_iss & sb_valid & ~reset;

    // Cache returns the whole aligned word; pick the lane and extend.
    always_comb begin
        ld_byte = dc_resp_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = dc_resp_rdata[7:0];
            2'b01:   ld_byte = dc_resp_rdata[15:8];
            2'b10:   ld_byte = dc_resp_rdata[23:16];
            default: ld_byte = dc_resp_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? dc_resp_rdata[31:16] : dc_resp_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{(DATA_W-8){ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   load_data = {{(DATA_W-16){ld_half[15] & ~uns_q}}, ld_half};
            default: load_data = dc_resp_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        prf_d        = prf_q;
        kill_d       = kill_q;
        src_d        = src_q;
        wb_valid_d   = 1'b0;
        wb_prf_d     = wb_prf_q;
        wb_data_d    = wb_data_q;
        sb_ready     = 1'b0;
        dc_req_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_iss) begin
                    we_d    = iss_is_store;
                    addr_d  = iss_addr;
                    wdata_d = iss_wdata;
                    size_d  = iss_size;
                    uns_d   = iss_unsigned;
                    prf_d   = iss_prf_index;
                    src_d   = 1'b0;
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end else if (grant_sb) begin
                    we_d     = 1'b1;
                    addr_d   = sb_addr;
                    wdata_d  = sb_wdata;
                    size_d   = sb_size;
                    uns_d    = 1'b0;
                    src_d    = 1'b1;
                    kill_d   = 1'b0;
                    sb_ready = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                dc_req_valid = 1'b1;
                // Drain stores are architecturally committed; flush never touches them.
                if (flush & ~we_q & ~src_q) begin
                    kill_d = 1'b1;
                end
                if (dc_req_ready) begin
                    state_d = we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dc_resp_valid) begin
                    wb_valid_d = ~(kill_q | flush);
                    wb_prf_d   = prf_q;
                    wb_data_d  = load_data;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sb_valid & ~sb_ready) begin
            starve_d = starving ? starve_q : starve_q + 8'd1;
        end else begin
            starve_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            prf_q      <= '0;
            kill_q     <= 1'b0;
            src_q      <= 1'b0;
            starve_q   <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_prf_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            prf_q      <= prf_d;
            kill_q     <= kill_d;
            src_q      <= src_d;
            starve_q   <= starve_d;
            wb_valid_q <= wb_valid_d;
            wb_prf_q   <= wb_prf_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign dc_req_we    = we_q;
    assign dc_req_addr  = addr_q;
    assign dc_req_wdata = wdata_q;
    assign dc_req_size  = size_q;
    assign wb_valid     = wb_valid_q;
    assign wb_prf_index = wb_prf_q;
    assign wb_data      = wb_data_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_loads_q;
    logic [31:0] perf_stores_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_loads_q  <= 32'd0;
            perf_stores_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if ((state_q == S_WAIT) && dc_resp_valid) begin
                perf_loads_q <= perf_loads_q + 32'd1;
            end
            if ((state_q == S_REQ) && dc_req_ready && we_q) begin
                perf_stores_q <= perf_stores_q + 32'd1;
            end
            if ((state_q == S_REQ) && !dc_req_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_loads      = perf_loads_q;
    assign perf_stores     = perf_stores_q;
    assign perf_port_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_mem_port_arbiter;

    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iss_valid = 1'b0, iss_is_store = 1'b0, iss_unsigned = 1'b0;
    logic [1:0]  iss_size = 2'b00;
    logic [31:0] iss_addr = '0, iss_wdata = '0;
    logic [5:0]  iss_prf_index = '0;
    logic        ex_busy;
    logic        sb_valid = 1'b0;
    logic [31:0] sb_addr = '0, sb_wdata = '0;
    logic [1:0]  sb_size = 2'b00;
    logic        sb_ready;
    logic        flush = 1'b0;
    logic        dc_req_valid, dc_req_we;
    logic        dc_req_ready = 1'b1;
    logic [31:0] dc_req_addr, dc_req_wdata;
    logic [1:0]  dc_req_size;
    logic        dc_resp_valid = 1'b0;
    logic [31:0] dc_resp_rdata = '0;
    logic        wb_valid;
    logic [5:0]  wb_prf_index;
    logic [31:0] wb_data;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TAG_W(6), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .iss_valid(iss_valid), .iss_is_store(iss_is_store), .iss_unsigned(iss_unsigned),
        .iss_size(iss_size), .iss_addr(iss_addr), .iss_wdata(iss_wdata),
        .iss_prf_index(iss_prf_index), .ex_busy(ex_busy),
        .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_size(sb_size),
        .sb_ready(sb_ready), .flush(flush),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_size(dc_req_size),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .wb_valid(wb_valid), .wb_prf_index(wb_prf_index), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference model: one in-flight access described as a record plus two phase flags.
    bit          m_pend, m_wait, m_kill, m_we, m_uns, m_sb;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [5:0]  m_prf;
    int          m_starve;
    bit          m_wbv;
    logic [31:0] m_wbd;
    logic [5:0]  m_wbp;

    function automatic logic [31:0] m_extract(logic [31:0] rd, logic [31:0] a,
                                              logic [1:0] sz, bit u);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit m_busy();
        return m_pend || m_wait || (m_starve == LIMIT && sb_valid);
    endfunction

    function automatic bit m_grant_iss();
        return !m_pend && !m_wait && iss_valid && !m_busy() && !flush;
    endfunction

    function automatic bit m_grant_sb();
        return !reset && !m_pend && !m_wait && sb_valid && !m_grant_iss();
    endfunction

    always @(posedge clock) begin : model
        bit gi, gs;
        gi = m_grant_iss();
        gs = m_grant_sb();
        if (reset) begin
            m_pend = 0; m_wait = 0; m_kill = 0; m_starve = 0; m_wbv = 0;
        end else begin
            m_wbv = 0;
            if (m_wait) begin
                if (flush) m_kill = 1;
                if (dc_resp_valid) begin
                    m_wait = 0;
                    m_wbv  = !m_kill;
                    m_wbd  = m_extract(dc_resp_rdata, m_addr, m_size, m_uns);
                    m_wbp  = m_prf;
                end
            end else if (m_pend) begin
                if (flush && !m_we && !m_sb) m_kill = 1;
                if (dc_req_ready) begin
                    m_pend = 0;
                    m_wait = !m_we;
                end
            end else if (gi) begin
                m_pend = 1; m_kill = 0; m_sb = 0;
                m_we = iss_is_store; m_addr = iss_addr; m_wdata = iss_wdata;
                m_size = iss_size; m_uns = iss_unsigned; m_prf = iss_prf_index;
            end else if (gs) begin
                m_pend = 1; m_kill = 0; m_sb = 1;
                m_we = 1; m_addr = sb_addr; m_wdata = sb_wdata; m_size = sb_size; m_uns = 0;
            end
            if (sb_valid && !gs) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else m_starve = 0;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("m_ex_busy", ex_busy, m_busy());
            chk("m_sb_ready", sb_ready, m_grant_sb());
            chk("m_dc_req_valid", dc_req_valid, m_pend);
            if (m_pend) begin
                chk("m_req_we", dc_req_we, m_we);
                chk("m_req_addr", dc_req_addr, m_addr);
                chk("m_req_wdata", dc_req_wdata, m_wdata);
                chk("m_req_size", dc_req_size, m_size);
            end
            chk("m_wb_valid", wb_valid, m_wbv);
            if (m_wbv) begin
                chk("m_wb_data", wb_data, m_wbd);
                chk("m_wb_prf", wb_prf_index, m_wbp);
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit u,
                           input logic [5:0] p, input logic [31:0] rd,
                           output logic [31:0] d, output logic v, output logic [5:0] pr);
        iss_valid = 1; iss_is_store = 0; iss_addr = a; iss_size = sz;
        iss_unsigned = u; iss_prf_index = p;
        cyc();
        iss_valid = 0;
        cyc();
        dc_resp_valid = 1; dc_resp_rdata = rd;
        cyc();
        dc_resp_valid = 0;
        d = wb_data; v = wb_valid; pr = wb_prf_index;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        v;
        logic [5:0]  pr;
        int          i;

        repeat (2) cyc();
        check_en = 1;
        chk("rst_dc_req_valid", dc_req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ex_busy", ex_busy, 0);
        chk("rst_sb_ready", sb_ready, 0);
        chk("rst_dc_req_addr", dc_req_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        reset = 0;
        cyc();

        // Signed byte load, lane 3.
        iss_valid = 1; iss_is_store = 0; iss_unsigned = 0; iss_size = 2'b00;
        iss_addr = 32'h1003; iss_prf_index = 6'd5;
        cyc();
        iss_valid = 0;
        chk("t1_req_valid_t1", dc_req_valid, 1);
        chk("t1_req_addr", dc_req_addr, 32'h1003);
        cyc();
        cyc();
        dc_resp_valid = 1; dc_resp_rdata = 32'h80FF_FFFF;
        chk("t1_wb_before_resp", wb_valid, 0);
        cyc();
        dc_resp_valid = 0;
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_prf", wb_prf_index, 6'd5);
        chk("t1_wb_data", wb_data, 32'hFFFF_FF80);
        cyc();
        chk("t1_wb_pulse", wb_valid, 0);

        // Issue store beats drain store in the same idle cycle.
        iss_valid = 1; iss_is_store = 1; iss_addr = 32'h40; iss_wdata = 32'h1122_3344;
        iss_size = 2'b10;
        sb_valid = 1; sb_addr = 32'h80; sb_wdata = 32'hAABB_CCDD; sb_size = 2'b10;
        chk("t2_sb_ready_lose", sb_ready, 0);
        cyc();
        iss_valid = 0;
        chk("t2_req_addr_iss", dc_req_addr, 32'h40);
        chk("t2_req_we", dc_req_we, 1);
        cyc();
        chk("t2_sb_ready_next_idle", sb_ready, 1);
        cyc();
        sb_valid = 0;
        chk("t2_req_addr_sb", dc_req_addr, 32'h80);
        chk("t2_req_wdata_sb", dc_req_wdata, 32'hAABB_CCDD);
        cyc();
        chk("t2_idle", ex_busy, 0);

        // Back-to-back issue stores starve the drain until the forced grant.
        iss_valid = 1; iss_is_store = 1; iss_addr = 32'h100; iss_wdata = 32'h5555;
        sb_valid = 1; sb_addr = 32'h200; sb_wdata = 32'h6666;
        i = 0;
        while (i < 20 && !sb_ready) begin
            cyc();
            i++;
        end
        chk("t3_grant_cycle", i, 8);
        chk("t3_forced_busy", ex_busy, 1);
        cyc();
        chk("t3_req_addr_sb", dc_req_addr, 32'h200);
        cyc();
        chk("t3_starve_cleared", ex_busy, 0);
        iss_valid = 0; sb_valid = 0;
        cyc();
        cyc();

        // Flush while waiting kills the writeback only.
        iss_valid = 1; iss_is_store = 0; iss_addr = 32'h3000; iss_size = 2'b10;
        iss_prf_index = 6'd7;
        cyc();
        iss_valid = 0;
        cyc();
        flush = 1;
        chk("t4_busy_wait", ex_busy, 1);
        cyc();
        flush = 0; dc_resp_valid = 1; dc_resp_rdata = 32'h1234_5678;
        cyc();
        dc_resp_valid = 0;
        chk("t4_killed_wb", wb_valid, 0);
        chk("t4_back_idle", ex_busy, 0);
        iss_valid = 1; iss_addr = 32'h3004; iss_prf_index = 6'd9; flush = 1;
        cyc();
        flush = 0;
        chk("t4_flush_ignores_iss", dc_req_valid, 0);
        cyc();
        iss_valid = 0;
        chk("t4_next_req", dc_req_valid, 1);
        cyc();
        dc_resp_valid = 1; dc_resp_rdata = 32'hCAFE_F00D;
        cyc();
        dc_resp_valid = 0;
        chk("t4_next_wb_valid", wb_valid, 1);
        chk("t4_next_wb_data", wb_data, 32'hCAFE_F00D);
        chk("t4_next_wb_prf", wb_prf_index, 6'd9);

        // Port stall, ignored issue while busy, then reset mid-request.
        dc_req_ready = 0;
        iss_valid = 1; iss_is_store = 0; iss_addr = 32'h4001; iss_size = 2'b01;
        iss_unsigned = 1; iss_prf_index = 6'd3;
        cyc();
        iss_valid = 1; iss_is_store = 1; iss_addr = 32'h9999;
        for (int k = 0; k < 3; k++) begin
            chk("t5_stall_valid", dc_req_valid, 1);
            chk("t5_stall_addr", dc_req_addr, 32'h4001);
            chk("t5_stall_busy", ex_busy, 1);
            if (k < 2) cyc();
        end
        reset = 1; iss_valid = 0;
        cyc();
        chk("t5_rst_req_valid", dc_req_valid, 0);
        chk("t5_rst_busy", ex_busy, 0);
        chk("t5_rst_addr", dc_req_addr, 0);
        chk("t5_rst_wb_data", wb_data, 0);
        reset = 0; dc_req_ready = 1; dc_resp_valid = 1; dc_resp_rdata = 32'hFFFF_FFFF;
        cyc();
        dc_resp_valid = 0;
        chk("t5_drop_resp0", wb_valid, 0);
        cyc();
        chk("t5_drop_resp1", wb_valid, 0);

        // Extraction table.
        do_load(32'h2002, 2'b01, 1, 6'd11, 32'hBEEF_1234, d, v, pr);
        chk("t6_half_u_valid", v, 1);
        chk("t6_half_u_data", d, 32'h0000_BEEF);
        chk("t6_half_u_prf", pr, 6'd11);
        do_load(32'h2002, 2'b01, 0, 6'd12, 32'hBEEF_1234, d, v, pr);
        chk("t6_half_s", d, 32'hFFFF_BEEF);
        do_load(32'h2001, 2'b01, 0, 6'd13, 32'hBEEF_1234, d, v, pr);
        chk("t6_half_lo_a0_ignored", d, 32'h0000_1234);
        do_load(32'h5001, 2'b00, 1, 6'd14, 32'h0000_A500, d, v, pr);
        chk("t6_byte_u", d, 32'h0000_00A5);
        do_load(32'h5002, 2'b00, 0, 6'd15, 32'h0080_0000, d, v, pr);
        chk("t6_byte_s", d, 32'hFFFF_FF80);
        do_load(32'h5000, 2'b11, 0, 6'd16, 32'h8765_4321, d, v, pr);
        chk("t6_size3_word", d, 32'h8765_4321);
        cyc();
        cyc();

        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
